// File: rtl/skewed_data_fetcher_if.sv
// Port bundle of the skewed data fetcher: store write port, stream control,
// per-lane stream outputs and FSM state for observation.
interface skewed_data_fetcher_if #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_SIZE   = 32
);
  localparam int AW = $clog2(MATRIX_SIZE * MATRIX_SIZE);

  // start is a one-cycle request honoured only while busy=0; valid_out[i]
  // qualifies data_out[i] on the same cycle; stall=1 freezes a running stream
  // and there is no back-pressure path towards the requester.
  logic                                  wr_en;
  logic [AW-1:0]                         wr_addr;
  logic [DATA_SIZE-1:0]                  wr_data;
  logic                                  start;
  logic                                  stall;
  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_out;
  logic [MATRIX_SIZE-1:0]                valid_out;
  logic                                  busy;
  logic                                  done;
  logic [1:0]                            state_dbg;

  modport master (
    output wr_en, wr_addr, wr_data, start, stall,
    input  data_out, valid_out, busy, done, state_dbg
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stall,
    output data_out, valid_out, busy, done, state_dbg
  );
endinterface

// File: rtl/skewed_data_fetcher.sv
// Streams an N x N word store as N rows, one row every INTERVAL cycles,
// optionally skewing lane i by i cycles for systolic-array entry.
module skewed_data_fetcher #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_SIZE   = 32,
  parameter int INTERVAL    = 4,
  parameter int SKEW_EN     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  skewed_data_fetcher_if.slave   bus
);
  localparam int N    = MATRIX_SIZE;
  localparam int AW   = $clog2(N * N);
  localparam int RW   = (N > 1) ? $clog2(N) : 1;
  localparam int CMAX = (INTERVAL > N) ? INTERVAL : N;
  localparam int CW   = $clog2(CMAX + 1);
  localparam bit DRAIN_EN = (SKEW_EN != 0) && (N > 1);
  localparam logic [CW-1:0] INT_RELOAD = CW'(INTERVAL - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = DRAIN_EN ? CW'(N - 2) : '0;
  localparam logic [RW-1:0] LAST_ROW   = RW'(N - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [RW-1:0]               row_q, row_d;
  logic [N-1:0][DATA_SIZE-1:0] data_q, data_d, lane_word, lane_data;
  logic [N-1:0]                valid_q, valid_d, lane_vld;
  logic                        done_q, done_d;
  logic                        advance, issue, wr_fire;
  logic [DATA_SIZE-1:0]        mem_q [N*N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = FETCH;
      FETCH: if (!bus.stall && cnt_q == '0 && row_q == LAST_ROW)
               state_d = DRAIN_EN ? DRAIN : DONE;
      DRAIN: if (!bus.stall && cnt_q == '0) state_d = DONE;
      DONE:  if (!bus.stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall is ignored in IDLE so the pipeline keeps flushing to zero there.
  always_comb begin
    advance = (state_q == IDLE) || !bus.stall;
    issue   = (state_q == FETCH) && !bus.stall && (cnt_q == '0);
    wr_fire = bus.wr_en && (state_q == IDLE);
    done_d  = (state_q == DONE) && !bus.stall;
    data_d  = advance ? lane_data : data_q;
    valid_d = advance ? lane_vld  : valid_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    row_d = row_q;
    case (state_q)
      IDLE: if (bus.start) begin
        cnt_d = '0;
        row_d = '0;
      end
      FETCH: if (!bus.stall) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (row_q == LAST_ROW) begin
          cnt_d = DRAIN_LOAD;
        end else begin
          cnt_d = INT_RELOAD;
          row_d = row_q + RW'(1);
        end
      end
      DRAIN: if (!bus.stall && cnt_q != '0) cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane_word[i] = issue ? mem_q[AW'(row_q) * AW'(N) + AW'(i)] : '0;
    end
  end

  // Lane i carries its word through i stages; zeros flow between issues.
  for (genvar i = 0; i < N; i++) begin : g_lane
    if (SKEW_EN != 0 && i > 0) begin : g_skew
      logic [DATA_SIZE-1:0] sk_data_q [i];
      logic [DATA_SIZE-1:0] sk_data_d [i];
      logic [i-1:0]         sk_vld_q, sk_vld_d;

      always_comb begin
        sk_data_d = sk_data_q;
        sk_vld_d  = sk_vld_q;
        if (advance) begin
          sk_data_d[0] = lane_word[i];
          sk_vld_d[0]  = issue;
          for (int j = 1; j < i; j++) begin
            sk_data_d[j] = sk_data_q[j-1];
            sk_vld_d[j]  = sk_vld_q[j-1];
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int j = 0; j < i; j++) sk_data_q[j] <= '0;
          sk_vld_q <= '0;
        end else begin
          sk_data_q <= sk_data_d;
          sk_vld_q  <= sk_vld_d;
        end
      end

      assign lane_data[i] = sk_data_q[i-1];
      assign lane_vld[i]  = sk_vld_q[i-1];
    end else begin : g_direct
      assign lane_data[i] = lane_word[i];
      assign lane_vld[i]  = issue;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      row_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Store contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[bus.wr_addr] <= bus.wr_data;
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_skewed_data_fetcher.sv
// Directed bench for skewed_data_fetcher: three configurations, a vector
// table for the 2-lane streams and hand sequences for the multi-cycle cases.
module tb_skewed_data_fetcher;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  skewed_data_fetcher_if #(.MATRIX_SIZE(2), .DATA_SIZE(32)) ia ();
  skewed_data_fetcher_if #(.MATRIX_SIZE(2), .DATA_SIZE(32)) ib ();
  skewed_data_fetcher_if #(.MATRIX_SIZE(4), .DATA_SIZE(32)) ic ();

  skewed_data_fetcher #(.MATRIX_SIZE(2), .DATA_SIZE(32), .INTERVAL(4), .SKEW_EN(1))
    u_a (.clk(clk), .reset(reset), .bus(ia));
  skewed_data_fetcher #(.MATRIX_SIZE(2), .DATA_SIZE(32), .INTERVAL(4), .SKEW_EN(0))
    u_b (.clk(clk), .reset(reset), .bus(ib));
  skewed_data_fetcher #(.MATRIX_SIZE(4), .DATA_SIZE(32), .INTERVAL(1), .SKEW_EN(1))
    u_c (.clk(clk), .reset(reset), .bus(ic));

  typedef struct {
    int          dut;
    logic        start;
    logic        stall;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  v;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(int dut, logic st, logic sl, logic [31:0] d0,
                              logic [31:0] d1, logic [1:0] v, logic b, logic dn);
    vec_t r;
    r.dut = dut; r.start = st; r.stall = sl; r.d0 = d0; r.d1 = d1;
    r.v = v; r.busy = b; r.done = dn;
    return r;
  endfunction

  function automatic logic [159:0] snap2(int d);
    if (d == 0) return {92'b0, ia.data_out, ia.valid_out, ia.busy, ia.done};
    return {92'b0, ib.data_out, ib.valid_out, ib.busy, ib.done};
  endfunction

  function automatic logic [159:0] snap_c();
    return {26'b0, ic.data_out, ic.valid_out, ic.busy, ic.done};
  endfunction

  function automatic logic [159:0] exp2(logic [31:0] d0, logic [31:0] d1,
                                        logic [1:0] v, logic b, logic dn);
    return {92'b0, d1, d0, v, b, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive2(input int d, input logic st, input logic sl);
    if (d == 0) begin ia.start = st; ia.stall = sl; end
    else        begin ib.start = st; ib.stall = sl; end
  endtask

  task automatic step_a(input string name, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] v, input logic b, input logic dn);
    tick();
    cmp(name, snap2(0), exp2(d0, d1, v, b, dn));
  endtask

  // Full unstalled stream on the 2-lane skewed unit; optional idle write with start.
  task automatic run_stream_a(input string tag, input logic wr, input logic [31:0] w0);
    ia.start = 1'b1;
    ia.wr_en = wr; ia.wr_addr = 2'd0; ia.wr_data = w0;
    step_a({tag, "_e0"}, 0, 0, 2'b00, 1, 0);
    ia.start = 1'b0; ia.wr_en = 1'b0;
    step_a({tag, "_e1"}, w0, 0, 2'b01, 1, 0);
    step_a({tag, "_e2"}, 0, 2, 2'b10, 1, 0);
    step_a({tag, "_e3"}, 0, 0, 2'b00, 1, 0);
    step_a({tag, "_e4"}, 0, 0, 2'b00, 1, 0);
    step_a({tag, "_e5"}, 3, 0, 2'b01, 1, 0);
    step_a({tag, "_e6"}, 0, 4, 2'b10, 1, 0);
    step_a({tag, "_e7"}, 0, 0, 2'b00, 0, 1);
    step_a({tag, "_e8"}, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    logic [3:0][31:0] ed;
    logic [3:0]       ev;
    int               r;

    reset = 1'b1;
    ia.wr_en = 0; ia.wr_addr = '0; ia.wr_data = '0; ia.start = 0; ia.stall = 0;
    ib.wr_en = 0; ib.wr_addr = '0; ib.wr_data = '0; ib.start = 0; ib.stall = 0;
    ic.wr_en = 0; ic.wr_addr = '0; ic.wr_data = '0; ic.start = 0; ic.stall = 0;
    tick();
    tick();
    cmp("reset_a", snap2(0), 160'b0);
    cmp("reset_b", snap2(1), 160'b0);
    cmp("reset_c", snap_c(), 160'b0);
    cmp("reset_state_a", {158'b0, ia.state_dbg}, 160'b0);
    reset = 1'b0;

    // Store a/b with 1..4 and c with 1..16.
    for (int k = 0; k < 16; k++) begin
      ic.wr_en = 1'b1; ic.wr_addr = 4'(k); ic.wr_data = 32'(k + 1);
      ia.wr_en = (k < 4); ia.wr_addr = 2'(k); ia.wr_data = 32'(k + 1);
      ib.wr_en = (k < 4); ib.wr_addr = 2'(k); ib.wr_data = 32'(k + 1);
      tick();
    end
    ia.wr_en = 0; ib.wr_en = 0; ic.wr_en = 0;

    // Skewed stream, with a start mid-FETCH that must be ignored.
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2'b01, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 2'b10, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 3, 0, 2'b01, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, 2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0));
    // Unskewed stream: stall in IDLE is harmless, start during DONE is dropped.
    vecs.push_back(mk(1, 1, 1, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 2, 2'b11, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 3, 4, 2'b11, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 2'b00, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
    // Skewed stream with a 3-cycle stall: everything later slips by 3.
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2'b01, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 3, 0, 2'b01, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, 2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0));

    foreach (vecs[i]) begin
      drive2(vecs[i].dut, vecs[i].start, vecs[i].stall);
      tick();
      cmp($sformatf("vec%0d", i), snap2(vecs[i].dut),
          exp2(vecs[i].d0, vecs[i].d1, vecs[i].v, vecs[i].busy, vecs[i].done));
    end
    drive2(0, 0, 0);
    drive2(1, 0, 0);

    // INTERVAL=1 on 4 lanes: back-to-back rows, lane i offset by i.
    for (int t = 0; t < 10; t++) begin
      ic.start = (t == 0);
      tick();
      for (int i = 0; i < 4; i++) begin
        r = t - 1 - i;
        ev[i] = (r >= 0 && r <= 3);
        ed[i] = ev[i] ? 32'(r * 4 + i + 1) : 32'd0;
      end
      cmp($sformatf("c_t%0d", t), snap_c(), {26'b0, ed, ev, (t <= 7), (t == 8)});
    end
    ic.start = 0;

    // Writes and start while busy are dropped; store and stream unchanged.
    ia.start = 1'b1;
    step_a("wb_e0", 0, 0, 2'b00, 1, 0);
    ia.wr_en = 1'b1; ia.wr_addr = 2'd2; ia.wr_data = 32'hAA;
    step_a("wb_e1", 1, 0, 2'b01, 1, 0);
    ia.wr_addr = 2'd0;
    step_a("wb_e2", 0, 2, 2'b10, 1, 0);
    ia.start = 1'b0; ia.wr_en = 1'b0;
    step_a("wb_e3", 0, 0, 2'b00, 1, 0);
    step_a("wb_e4", 0, 0, 2'b00, 1, 0);
    step_a("wb_e5", 3, 0, 2'b01, 1, 0);
    step_a("wb_e6", 0, 4, 2'b10, 1, 0);
    step_a("wb_e7", 0, 0, 2'b00, 0, 1);
    step_a("wb_e8", 0, 0, 2'b00, 0, 0);
    run_stream_a("post_wb", 1'b0, 32'd1);
    run_stream_a("idle_wr", 1'b1, 32'hAA);
    run_stream_a("restore", 1'b1, 32'd1);

    // Reset between row issues aborts at once; store survives.
    ia.start = 1'b1;
    step_a("rst_e0", 0, 0, 2'b00, 1, 0);
    ia.start = 1'b0;
    step_a("rst_e1", 1, 0, 2'b01, 1, 0);
    step_a("rst_e2", 0, 2, 2'b10, 1, 0);
    #2 reset = 1'b1;
    #1 cmp("rst_async", snap2(0), 160'b0);
    #1 reset = 1'b0;
    for (int k = 0; k < 6; k++) step_a($sformatf("rst_quiet%0d", k), 0, 0, 2'b00, 0, 0);
    run_stream_a("rst_replay", 1'b0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
